// File: rtl/psc_pkg.sv
// psc_pkg: shared FSM state type and status codes for serial_pattern_scan_ctrl.
// Revision: 1.0
`default_nettype none

package psc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] STS_OK      = 2'b00;
  localparam logic [1:0] STS_CFG_ERR = 2'b01;
  localparam logic [1:0] STS_ABORT   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/pattern_match_window.sv
// pattern_match_window: bit history, fill count and length-masked pattern compare.
// Revision: 1.0 -- overlap behaviour selected by PSC_OVERLAP_EN.
`default_nettype none

module pattern_match_window #(
  parameter int PAT_W = 6,
  parameter int PL_W  = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [PL_W-1:0]  plen,
  output logic             hit
);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_nxt;
  logic [PAT_W-1:0] mask;
  logic [PL_W-1:0]  fill;
  logic [PL_W-1:0]  fill_nxt;
  logic [PL_W:0]    fill_inc;

  // Only the plen most recent history bits take part in the compare.
  generate
    for (genvar i = 0; i < PAT_W; i++) begin : g_mask
      assign mask[i] = (int'(plen) > i);
    end
  endgenerate

  always_comb begin
    hist_nxt = {hist[PAT_W-2:0], bit_in};
    fill_inc = {1'b0, fill} + (PL_W+1)'(1);
    fill_nxt = (fill_inc >= {1'b0, plen}) ? plen : fill_inc[PL_W-1:0];
    hit      = shift && (fill_nxt == plen) && ((hist_nxt & mask) == (pattern & mask));
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_nxt;
`ifdef PSC_OVERLAP_EN
      fill <= fill_nxt;
`else
      fill <= hit ? '0 : fill_nxt;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_pattern_scan_ctrl.sv
// serial_pattern_scan_ctrl: scans a framed serial stream for a programmable pattern and counts matches.
// Revision: 1.0 -- optional overlapping matches via PSC_OVERLAP_EN.
`default_nettype none

module serial_pattern_scan_ctrl
  import psc_pkg::*;
#(
  parameter int PAT_W = 6,
  parameter int LEN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         abort,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_plen,
  input  logic [LEN_W-1:0]             cfg_frame,
  input  logic                         s_valid,
  input  logic                         s_bit,
  output logic                         s_ready,
  output logic                         busy,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         done,
  output logic [1:0]                   sts
);

  localparam int PL_W = $clog2(PAT_W + 1);

  state_t           state;
  state_t           state_nxt;
  logic [PAT_W-1:0] pattern_q;
  logic [PL_W-1:0]  plen_q;
  logic [LEN_W-1:0] frame_q;
  logic [LEN_W-1:0] bitcnt;
  logic             accept;
  logic             last_bit;
  logic             cfg_bad;
  logic             hit;

  assign cfg_bad  = (cfg_plen == '0) || (cfg_plen > PL_W'(PAT_W));
  assign last_bit = ((bitcnt + LEN_W'(1)) == frame_q);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (cfg_bad || (cfg_frame == '0)) state_nxt = DONE;
        else                              state_nxt = SCAN;
      end
      SCAN: begin
        // abort wins over a simultaneous bit: ready drops so nothing is consumed
        s_ready = !abort;
        accept  = s_valid && !abort;
        if (abort)                     state_nxt = DONE;
        else if (accept && last_bit)   state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  pattern_match_window #(
    .PAT_W (PAT_W),
    .PL_W  (PL_W)
  ) u_window (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (state == LOAD),
    .shift   (accept),
    .bit_in  (s_bit),
    .pattern (pattern_q),
    .plen    (plen_q),
    .hit     (hit)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pattern_q <= '0;
      plen_q    <= '0;
      frame_q   <= '0;
      bitcnt    <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
      sts       <= STS_OK;
    end else begin
      match <= 1'b0;
      if (state == LOAD) begin
        pattern_q <= cfg_pattern;
        plen_q    <= cfg_plen;
        frame_q   <= cfg_frame;
        bitcnt    <= '0;
        match_cnt <= '0;
        sts       <= cfg_bad ? STS_CFG_ERR : STS_OK;
      end else if (state == SCAN) begin
        if (abort) begin
          sts <= STS_ABORT;
        end else if (accept) begin
          bitcnt <= bitcnt + LEN_W'(1);
          if (hit) begin
            match <= 1'b1;
            if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/serial_pattern_scan_ctrl.md
Name: serial_pattern_scan_ctrl

Overview:
- Controller that sequences a serial bit stream through a programmable pattern matcher for a configured frame length.
- Matches are counted and a completion status is reported.
- Generalises the fixed 3-bit detectors to a run-time pattern of up to PAT_W bits.
- Sits between a bit source (valid/ready) and software-visible config/status registers.

Parameters:
- PAT_W, 6, maximum pattern length in bits (>=2)
- LEN_W, 16, width of frame-length and bit counters
- CNT_W, 8, width of match counter (saturating)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous, active-low reset
- start  in  1  begin a scan (sampled only in IDLE)
- abort  in  1  terminate a scan in progress
- cfg_pattern  in  PAT_W  pattern; bit [plen-1] is the earliest bit, bit [0] the most recent
- cfg_plen  in  $clog2(PAT_W+1)  pattern length, legal 1..PAT_W
- cfg_frame  in  LEN_W  number of bits to scan
- s_valid  in  1  input bit valid
- s_bit  in  1  input bit
- s_ready  out  1  bit accepted when s_valid&&s_ready
- busy  out  1  state != IDLE
- match  out  1  one-cycle pulse, registered
- match_cnt  out  CNT_W  matches in current/last scan
- done  out  1  one-cycle pulse at scan end
- sts  out  2  00 ok, 01 config error, 10 aborted

Behaviour:
- Reset values: state=IDLE; all outputs 0; history, fill count, bit counter and latched config cleared.
- States:
  - IDLE: start -> LOAD.
  - LOAD (1 cycle): latch cfg_*, clear history/fill/bit counter/match_cnt, sts=00.
    - cfg_plen==0 or >PAT_W -> DONE with sts=01.
    - Else cfg_frame==0 -> DONE with sts=00.
    - Else -> SCAN.
  - SCAN: s_ready=1.
    - On accept: hist <= {hist[PAT_W-2:0], s_bit}; fill <= min(fill+1, plen); bitcnt++.
    - Accept of bit number cfg_frame -> DONE.
  - DONE (1 cycle): done=1 -> IDLE.
- Match condition: evaluated on the updated history, on an accept cycle only: new fill >= plen and hist[plen-1:0] == cfg_pattern[plen-1:0].
  - match pulses the cycle after the accepting edge.
  - match_cnt increments in the same cycle and saturates at 2^CNT_W-1.
- Last-bit match: match, the final match_cnt update and done are all asserted in the same cycle.
- s_ready is 0 in IDLE, LOAD and DONE; s_valid there is ignored and no data is consumed.
- Config inputs are ignored outside LOAD; changes mid-scan have no effect.
- start outside IDLE is ignored; start during DONE is not queued.
- abort in SCAN:
  - takes priority over a simultaneous accept; the bit is not consumed, since s_ready is forced low combinationally when abort=1;
  - -> DONE with sts=10;
  - match_cnt holds its value.
- abort in other states is ignored.
- match_cnt and sts hold after DONE until the next LOAD.
- rstn low mid-scan: immediate return to reset values at that edge, no done pulse.

Optional Feature:
- Macro: PSC_OVERLAP_EN.
- Defined: overlapping matches allowed; fill is unaffected by a match.
- Undefined: after a match, fill clears to 0, so the next match needs plen fresh bits.

Decomposition:
- Package psc_pkg:
  - state enum {IDLE, LOAD, SCAN, DONE};
  - status constants STS_OK=2'b00, STS_CFG_ERR=2'b01, STS_ABORT=2'b10.
- Sub-module pattern_match_window:
  - contains the history shift register, fill counter and masked compare;
  - inputs clear, shift, bit, pattern, plen;
  - output hit, combinational on the next-state history.
- The top level holds the FSM, counters and handshake.

Test Plan:
- pattern=000010, plen=3, frame=5, stream 0,1,0,1,0 (s_valid always 1):
  - PSC_OVERLAP_EN: match after bits 3 and 5, match_cnt=2, sts=00;
  - without it: match after bit 3 only, match_cnt=1.
- pattern=000110, plen=3, frame=8, stream 1,0,1,1,0,1,1,0 with s_valid deasserted every other cycle: matches after bits 5 and 8; done in the same cycle as the second match; match_cnt=2.
- plen=0, start -> busy 2 cycles, no s_ready, done with sts=01. Repeat with plen=7 (PAT_W=6): same result.
- frame=0, start -> done 2 cycles after start, match_cnt=0, sts=00, s_ready never high.
- frame=100, abort asserted with s_valid=1 after 10 accepts -> that bit is not consumed; done next cycle, sts=10, match_cnt holds.
- CNT_W=2, pattern=000001, plen=1, frame=6, all ones -> match_cnt saturates at 3; match still pulses 6 times.
- rstn low mid-SCAN -> next cycle all outputs 0, state IDLE; a new start then runs normally.
